// File: rtl/seven_seg_scan_bcd.sv
// Multi-digit common-anode 7-segment scan driver with a sequential
// shift-add-3 binary-to-BCD converter, leading-zero blanking and overflow dashes.
module seven_seg_scan_bcd #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned BIN_W          = 16,
  parameter int unsigned REFRESH_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    value,
  input  logic                load,
  input  logic [N_DIGITS-1:0] dp_mask,
  input  logic                lz_blank,
  output logic                busy,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] dig
);

  localparam int unsigned BCD_W   = 4 * N_DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned DWELL_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(N_DIGITS);
  localparam logic [6:0]  PAT_BLANK = 7'b1111111;
  localparam logic [6:0]  PAT_DASH  = 7'b0111111;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0011000;
      default: return PAT_BLANK;
    endcase
  endfunction

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state;
  logic [BIN_W-1:0]    bin_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_next;
  logic [BCD_W-1:0]    disp_bcd;
  logic                ovf_pend;
  logic                disp_ovf;
  logic [CNT_W-1:0]    cnt;
  logic [DWELL_W-1:0]  dwell;
  logic [IDX_W-1:0]    scan_idx;

  // One double-dabble step: correct nibbles >= 5, then shift in the next binary MSB
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      ovf_pend <= 1'b0;
      cnt      <= '0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_q    <= value;
            bcd_q    <= '0;
            ovf_pend <= (64'(value) >= OVF_LIMIT);
            cnt      <= CNT_W'(BIN_W);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_next;
          bin_q <= bin_q << 1;
          cnt   <= cnt - CNT_W'(1);
          // Last shift: publish the finished result to the display registers
          if (cnt == CNT_W'(1)) begin
            disp_bcd <= bcd_next;
            disp_ovf <= ovf_pend;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Dwell timer and digit pointer, scanning from MSD down to digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell    <= '0;
      scan_idx <= IDX_W'(N_DIGITS - 1);
    end else if (dwell == DWELL_W'(REFRESH_CYCLES - 1)) begin
      dwell    <= '0;
      scan_idx <= (scan_idx == '0) ? IDX_W'(N_DIGITS - 1) : scan_idx - IDX_W'(1);
    end else begin
      dwell <= dwell + DWELL_W'(1);
    end
  end

  logic [3:0] cur_nib;
  logic       blank_sel;
  logic       dp_sel;
  logic       zero_run;
  logic [6:0] pat;

  // Select the scanned digit; zero_run tracks "this digit and all above are zero"
  always_comb begin
    cur_nib   = '0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    zero_run  = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_bcd[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == scan_idx) begin
        cur_nib   = disp_bcd[4*i +: 4];
        blank_sel = zero_run && (i != 0);
        dp_sel    = dp_mask[i];
      end
    end
    if (disp_ovf)                  pat = PAT_DASH;
    else if (lz_blank && blank_sel) pat = PAT_BLANK;
    else                           pat = seg7(cur_nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 8'hFF;
      dig <= '1;
    end else begin
      seg <= {~dp_sel, pat};
      dig <= ~(N_DIGITS'(1) << scan_idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_bcd.sv
// Randomised and directed bench for seven_seg_scan_bcd, checked against a
// decimal-arithmetic model of what each scanned digit should show.
module tb_seven_seg_scan_bcd;

  localparam int N  = 4;
  localparam int BW = 16;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          lz_blank = 1'b0;
  logic [BW-1:0] value = '0;
  logic [N-1:0]  dp_mask = '0;
  logic          busy;
  logic [7:0]    seg;
  logic [N-1:0]  dig;

  int total = 0;
  int bad   = 0;
  int k;
  int exp_val  = 0;
  bit exp_ovf  = 1'b0;
  bit pend     = 1'b0;
  int pend_val = 0;
  bit pend_ovf = 1'b0;

  seven_seg_scan_bcd #(.N_DIGITS(N), .BIN_W(BW), .REFRESH_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_mask(dp_mask),
    .lz_blank(lz_blank), .busy(busy), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; locates the scanned digit in the model
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] digit_pat(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0011000;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    logic [6:0] p;
    if (exp_ovf)                                     p = 7'b0111111;
    else if (lz_blank && d != 0 && exp_val < pow10(d)) p = 7'b1111111;
    else                                             p = digit_pat((exp_val / pow10(d)) % 10);
    return {~dp_mask[d], p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick_check();
    int d;
    logic [N-1:0] ed;
    @(negedge clk);
    if (pend) begin
      exp_val = pend_val;
      exp_ovf = pend_ovf;
      pend    = 1'b0;
    end
    if (rst || k == 0) begin
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_dig", 32'(dig), 32'(4'hF));
      chk("rst_busy", 32'(busy), 32'd0);
    end else begin
      d  = N - 1 - (((k - 1) / R) % N);
      ed = ~(N'(1) << d);
      chk("dig", 32'(dig), 32'(ed));
      chk("seg", 32'(seg), 32'(exp_seg(d)));
    end
  endtask

  // Caller is at a negedge; optional extra load pulse during busy at step extra_at
  task automatic do_load(input int v, input int extra_at, input int extra_v);
    value = BW'(v);
    load  = 1'b1;
    tick_check();
    load = 1'b0;
    for (int i = 0; i < BW; i++) begin
      chk("busy_hi", 32'(busy), 32'd1);
      if (i == extra_at) begin
        value = BW'(extra_v);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick_check();
    end
    load = 1'b0;
    chk("busy_lo", 32'(busy), 32'd0);
    pend     = 1'b1;
    pend_val = v;
    pend_ovf = (v >= pow10(N));
  endtask

  initial begin
    repeat (3) tick_check();
    rst = 1'b0;
    repeat (21) tick_check();

    // Asynchronous reset in the middle of a scan
    rst = 1'b1;
    #1;
    chk("async_seg", 32'(seg), 32'hFF);
    chk("async_dig", 32'(dig), 32'(4'hF));
    chk("async_busy", 32'(busy), 32'd0);
    tick_check();
    rst = 1'b0;
    repeat (6) tick_check();

    lz_blank = 1'b0; dp_mask = '0;
    do_load(1234, -1, 0);
    repeat (2 * N * R) tick_check();

    lz_blank = 1'b1; dp_mask = 4'b0010;
    do_load(7, -1, 0);
    repeat (N * R + 2) tick_check();

    dp_mask = '0;
    do_load(10000, -1, 0);
    repeat (N * R) tick_check();
    do_load(0, -1, 0);
    repeat (N * R) tick_check();

    do_load(42, 2, 99);
    repeat (N * R) tick_check();

    // Load on the cycle busy falls is accepted
    lz_blank = 1'b0;
    do_load(321, -1, 0);
    do_load(9876, -1, 0);
    repeat (N * R) tick_check();

    // Reset during conversion aborts it with no later commit
    lz_blank = 1'b1;
    value = BW'(5555);
    load  = 1'b1;
    tick_check();
    load = 1'b0;
    repeat (7) begin
      chk("busy_pre_rst", 32'(busy), 32'd1);
      tick_check();
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_seg", 32'(seg), 32'hFF);
    exp_val = 0;
    exp_ovf = 1'b0;
    pend    = 1'b0;
    tick_check();
    rst = 1'b0;
    repeat (40) tick_check();

    for (int it = 0; it < 24; it++) begin
      int v;
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 9));
        1:       v = int'($urandom_range(0, 999));
        2:       v = int'($urandom_range(0, 9999));
        default: v = int'($urandom_range(0, 65535));
      endcase
      lz_blank = 1'($urandom_range(0, 1));
      dp_mask  = N'($urandom);
      do_load(v, -1, 0);
      repeat ($urandom_range(1, 2 * N * R)) tick_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
